// File: rtl/router_fsm_param.sv
// router_fsm_param: packet-control FSM for the router.
// It decodes the header address and steers writes into one of NUM_PORTS
// output FIFOs. It then sequences the first-data, payload, full-stall,
// parity and parity-check phases. A destination whose FIFO stays busy is
// waited on for at most TIMEOUT_CYCLES. Invalid or timed-out packets are
// drained through DROP_PACKET without any FIFO writes.
module router_fsm_param #(
    parameter int NUM_PORTS      = 3,
    parameter int ADDR_W         = 2,
    parameter int TIMEOUT_CYCLES = 30
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    output logic                 busy,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 drop_state,
    output logic                 write_enb_reg,
    output logic [NUM_PORTS-1:0] fifo_sel,
    output logic [ADDR_W-1:0]    addr_out,
    output logic                 timeout_err
);

    // Wide enough to hold TIMEOUT_CYCLES-1 for any TIMEOUT_CYCLES >= 1.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int ADDR_SPACE = 2 ** ADDR_W;

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        FIFO_FULL_STATE    = 4'd3,
        LOAD_AFTER_FULL    = 4'd4,
        LOAD_PARITY        = 4'd5,
        CHECK_PARITY_ERROR = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_W-1:0]     addr_reg;
    logic [CNT_W-1:0]      wait_cnt;
    logic [ADDR_SPACE-1:0] empty_ext;
    logic [ADDR_SPACE-1:0] soft_ext;
    logic                  addr_valid;
    logic                  sel_phase;

    // Pad the per-port flags to the full address space. Any address can then
    // index them safely. Unused addresses read as "not empty, no soft reset".
    always_comb begin
        empty_ext = '0;
        soft_ext  = '0;
        empty_ext[NUM_PORTS-1:0] = fifo_empty;
        soft_ext[NUM_PORTS-1:0]  = soft_reset;
    end

    assign addr_valid = (32'(data_in) < NUM_PORTS);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= DECODE_ADDRESS;
        else       state <= next_state;
    end

    // Next-state logic. A soft reset on the packet's own port overrides the
    // normal transitions everywhere except in DECODE_ADDRESS.
    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (!addr_valid)             next_state = DROP_PACKET;
                    else if (empty_ext[data_in]) next_state = LOAD_FIRST_DATA;
                    else                         next_state = WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       next_state = FIFO_FULL_STATE;
                else if (!pkt_valid) next_state = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        next_state = DECODE_ADDRESS;
                else if (low_pkt_valid) next_state = LOAD_PARITY;
                else                    next_state = LOAD_DATA;
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                if (!fifo_full) next_state = DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                // The FIFO draining wins over a coincident timeout.
                if (empty_ext[addr_reg])         next_state = LOAD_FIRST_DATA;
                else if (wait_cnt == TIMEOUT_LAST) next_state = DROP_PACKET;
            end
            DROP_PACKET: begin
                if (!pkt_valid) next_state = DECODE_ADDRESS;
            end
            default: next_state = DECODE_ADDRESS;
        endcase
        if (state != DECODE_ADDRESS && soft_ext[addr_reg])
            next_state = DECODE_ADDRESS;
    end

    // Capture the destination when a header is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            addr_reg <= '0;
        else if (state == DECODE_ADDRESS && pkt_valid)
            addr_reg <= data_in;
    end

    // Count cycles spent waiting. The count restarts on every fresh wait.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (state == WAIT_TILL_EMPTY)
            wait_cnt <= wait_cnt + CNT_W'(1);
        else
            wait_cnt <= '0;
    end

    // Pulse timeout_err during the first DROP_PACKET cycle after a wait
    // expires. It does not pulse when a soft reset pre-empted the drop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            timeout_err <= 1'b0;
        else
            timeout_err <= (state == WAIT_TILL_EMPTY) && (next_state == DROP_PACKET);
    end

    // Moore decodes: the outputs depend only on registered state.
    assign detect_add    = (state == DECODE_ADDRESS);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign drop_state    = (state == DROP_PACKET);
    assign busy          = (state == LOAD_FIRST_DATA) || (state == FIFO_FULL_STATE) ||
                           (state == LOAD_AFTER_FULL) || (state == LOAD_PARITY) ||
                           (state == CHECK_PARITY_ERROR) || (state == WAIT_TILL_EMPTY);
    assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_AFTER_FULL) ||
                           (state == LOAD_PARITY);
    assign addr_out      = addr_reg;

    // The destination is selected only while the packet owns its FIFO.
    assign sel_phase = (state == LOAD_FIRST_DATA) || (state == LOAD_DATA) ||
                       (state == FIFO_FULL_STATE) || (state == LOAD_AFTER_FULL) ||
                       (state == LOAD_PARITY) || (state == CHECK_PARITY_ERROR);

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_sel
        assign fifo_sel[i] = sel_phase && (addr_reg == ADDR_W'(i));
    end

endmodule

// File: tb/tb_router_fsm_param.sv
// Directed testbench for router_fsm_param (NUM_PORTS=3, ADDR_W=2,
// TIMEOUT_CYCLES=30). Inputs change 1 time unit after the rising edge.
// Outputs are sampled at the same point.
module tb_router_fsm_param;

    localparam int NP = 3;
    localparam int AW = 2;

    // Observed-state codes derived from the Moore decode outputs.
    localparam int S_DA = 0, S_LFD = 1, S_LD = 2, S_FFS = 3, S_LAF = 4,
                   S_LP = 5, S_CPE = 6, S_WTE = 7, S_DROP = 8, S_BAD = 15;

    logic          clock, reset, pkt_valid, parity_done, low_pkt_valid, fifo_full;
    logic [AW-1:0] data_in;
    logic [NP-1:0] fifo_empty, soft_reset;
    logic          busy, detect_add, lfd_state, ld_state, laf_state, full_state;
    logic          rst_int_reg, drop_state, write_enb_reg, timeout_err;
    logic [NP-1:0] fifo_sel;
    logic [AW-1:0] addr_out;

    int passed = 0;
    int total  = 0;

    router_fsm_param #(.NUM_PORTS(NP), .ADDR_W(AW), .TIMEOUT_CYCLES(30)) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .soft_reset(soft_reset), .busy(busy),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .drop_state(drop_state), .write_enb_reg(write_enb_reg), .fifo_sel(fifo_sel),
        .addr_out(addr_out), .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int obs();
        if (detect_add)    return S_DA;
        if (lfd_state)     return S_LFD;
        if (ld_state)      return S_LD;
        if (full_state)    return S_FFS;
        if (laf_state)     return S_LAF;
        if (rst_int_reg)   return S_CPE;
        if (drop_state)    return S_DROP;
        if (write_enb_reg) return S_LP;
        if (busy)          return S_WTE;
        return S_BAD;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++; if (detect_add !== 1'b1) $display("FAIL rst_detect_add got=%b exp=1", detect_add); else passed++;
        total++; if ({busy, lfd_state, ld_state, laf_state, full_state, rst_int_reg, drop_state, write_enb_reg, timeout_err} !== 9'b0)
            $display("FAIL rst_flags got=%b exp=0", {busy, lfd_state, ld_state, laf_state, full_state, rst_int_reg, drop_state, write_enb_reg, timeout_err});
        else passed++;
        total++; if ({fifo_sel, addr_out} !== 5'b0) $display("FAIL rst_sel_addr got=%b exp=0", {fifo_sel, addr_out}); else passed++;
        @(negedge clock);
        reset = 1'b0;
        tick();
        total++; if (obs() !== S_DA) $display("FAIL rst_idle got=%0d exp=%0d", obs(), S_DA); else passed++;
    endtask

    task automatic test_basic_packet();
        int we_cnt;
        we_cnt = 0;
        pkt_valid = 1'b1; data_in = 2'b01;
        tick();
        total++; if (obs() !== S_LFD) $display("FAIL basic_lfd got=%0d exp=%0d", obs(), S_LFD); else passed++;
        total++; if (fifo_sel !== 3'b010) $display("FAIL basic_sel_lfd got=%b exp=010", fifo_sel); else passed++;
        total++; if (addr_out !== 2'b01) $display("FAIL basic_addr got=%b exp=01", addr_out); else passed++;
        if (write_enb_reg) we_cnt++;
        for (int i = 0; i < 4; i++) begin
            data_in = AW'(i + 2);
            tick();
            total++; if (obs() !== S_LD) $display("FAIL basic_ld%0d got=%0d exp=%0d", i, obs(), S_LD); else passed++;
            if (write_enb_reg) we_cnt++;
        end
        total++; if (fifo_sel !== 3'b010) $display("FAIL basic_sel_ld got=%b exp=010", fifo_sel); else passed++;
        pkt_valid = 1'b0;
        tick();
        total++; if (obs() !== S_LP) $display("FAIL basic_lp got=%0d exp=%0d", obs(), S_LP); else passed++;
        if (write_enb_reg) we_cnt++;
        tick();
        total++; if (obs() !== S_CPE) $display("FAIL basic_cpe got=%0d exp=%0d", obs(), S_CPE); else passed++;
        if (write_enb_reg) we_cnt++;
        tick();
        total++; if (obs() !== S_DA) $display("FAIL basic_da got=%0d exp=%0d", obs(), S_DA); else passed++;
        total++; if (fifo_sel !== 3'b000) $display("FAIL basic_sel_da got=%b exp=000", fifo_sel); else passed++;
        total++; if (we_cnt !== 5) $display("FAIL basic_we_cycles got=%0d exp=5", we_cnt); else passed++;
    endtask

    task automatic test_wait_release();
        fifo_empty = 3'b011;
        pkt_valid = 1'b1; data_in = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (obs() !== S_WTE) $display("FAIL wait_wte%0d got=%0d exp=%0d", i, obs(), S_WTE); else passed++;
            total++; if ({busy, fifo_sel, timeout_err} !== 5'b10000) $display("FAIL wait_flags%0d got=%b exp=10000", i, {busy, fifo_sel, timeout_err}); else passed++;
        end
        fifo_empty = 3'b111;
        tick();
        total++; if (obs() !== S_LFD) $display("FAIL wait_lfd got=%0d exp=%0d", obs(), S_LFD); else passed++;
        total++; if ({fifo_sel, timeout_err} !== 4'b1000) $display("FAIL wait_sel got=%b exp=1000", {fifo_sel, timeout_err}); else passed++;
        pkt_valid = 1'b0;
        tick(); tick(); tick(); tick();
        total++; if (obs() !== S_DA) $display("FAIL wait_end got=%0d exp=%0d", obs(), S_DA); else passed++;
    endtask

    task automatic test_timeout();
        int te_seen;
        te_seen = 0;
        fifo_empty = 3'b110;
        pkt_valid = 1'b1; data_in = 2'b00;
        tick();
        total++; if (obs() !== S_WTE) $display("FAIL to_wte got=%0d exp=%0d", obs(), S_WTE); else passed++;
        for (int i = 0; i < 29; i++) begin
            tick();
            if (timeout_err || obs() != S_WTE) te_seen++;
        end
        total++; if (te_seen !== 0) $display("FAIL to_early_exit got=%0d exp=0", te_seen); else passed++;
        tick();
        total++; if (obs() !== S_DROP) $display("FAIL to_drop got=%0d exp=%0d", obs(), S_DROP); else passed++;
        total++; if ({timeout_err, write_enb_reg, fifo_sel, busy} !== 6'b100000) $display("FAIL to_pulse got=%b exp=100000", {timeout_err, write_enb_reg, fifo_sel, busy}); else passed++;
        tick();
        total++; if ({drop_state, timeout_err} !== 2'b10) $display("FAIL to_pulse_width got=%b exp=10", {drop_state, timeout_err}); else passed++;
        pkt_valid = 1'b0;
        tick();
        total++; if (obs() !== S_DA) $display("FAIL to_da got=%0d exp=%0d", obs(), S_DA); else passed++;

        // The FIFO empties on the very cycle the wait would expire.
        pkt_valid = 1'b1;
        tick();
        for (int i = 0; i < 29; i++) tick();
        fifo_empty = 3'b111;
        tick();
        total++; if (obs() !== S_LFD) $display("FAIL to_tie_lfd got=%0d exp=%0d", obs(), S_LFD); else passed++;
        total++; if (timeout_err !== 1'b0) $display("FAIL to_tie_err got=%b exp=0", timeout_err); else passed++;
        pkt_valid = 1'b0;
        tick(); tick(); tick(); tick();
        total++; if (obs() !== S_DA) $display("FAIL to_tie_end got=%0d exp=%0d", obs(), S_DA); else passed++;
    endtask

    task automatic test_invalid_addr();
        pkt_valid = 1'b1; data_in = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (obs() !== S_DROP) $display("FAIL inv_drop%0d got=%0d exp=%0d", i, obs(), S_DROP); else passed++;
            total++; if ({write_enb_reg, fifo_sel, timeout_err} !== 5'b0) $display("FAIL inv_quiet%0d got=%b exp=0", i, {write_enb_reg, fifo_sel, timeout_err}); else passed++;
        end
        total++; if (addr_out !== 2'b11) $display("FAIL inv_addr got=%b exp=11", addr_out); else passed++;
        pkt_valid = 1'b0;
        tick();
        total++; if (obs() !== S_DA) $display("FAIL inv_da got=%0d exp=%0d", obs(), S_DA); else passed++;
    endtask

    task automatic test_fifo_full();
        pkt_valid = 1'b1; data_in = 2'b01;
        tick(); tick();
        total++; if (obs() !== S_LD) $display("FAIL full_ld got=%0d exp=%0d", obs(), S_LD); else passed++;
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (obs() !== S_FFS) $display("FAIL full_ffs%0d got=%0d exp=%0d", i, obs(), S_FFS); else passed++;
        end
        total++; if ({busy, write_enb_reg} !== 2'b10) $display("FAIL full_flags got=%b exp=10", {busy, write_enb_reg}); else passed++;
        fifo_full = 1'b0; low_pkt_valid = 1'b1;
        tick();
        total++; if (obs() !== S_LAF) $display("FAIL full_laf got=%0d exp=%0d", obs(), S_LAF); else passed++;
        total++; if ({busy, write_enb_reg} !== 2'b11) $display("FAIL full_laf_flags got=%b exp=11", {busy, write_enb_reg}); else passed++;
        pkt_valid = 1'b0;
        tick();
        total++; if (obs() !== S_LP) $display("FAIL full_lp got=%0d exp=%0d", obs(), S_LP); else passed++;
        low_pkt_valid = 1'b0;
        tick();
        total++; if (obs() !== S_CPE) $display("FAIL full_cpe got=%0d exp=%0d", obs(), S_CPE); else passed++;
        tick();
        total++; if (obs() !== S_DA) $display("FAIL full_da got=%0d exp=%0d", obs(), S_DA); else passed++;
    endtask

    task automatic test_soft_reset();
        pkt_valid = 1'b1; data_in = 2'b01;
        tick(); tick();
        soft_reset = 3'b001;
        tick();
        total++; if (obs() !== S_LD) $display("FAIL srst_other got=%0d exp=%0d", obs(), S_LD); else passed++;
        soft_reset = 3'b010;
        tick();
        total++; if (obs() !== S_DA) $display("FAIL srst_own got=%0d exp=%0d", obs(), S_DA); else passed++;
        soft_reset = 3'b000; pkt_valid = 1'b0;
        tick();
        total++; if (obs() !== S_DA) $display("FAIL srst_idle got=%0d exp=%0d", obs(), S_DA); else passed++;
    endtask

    task automatic test_async_reset();
        pkt_valid = 1'b1; data_in = 2'b10;
        tick(); tick();
        total++; if (obs() !== S_LD) $display("FAIL arst_pre got=%0d exp=%0d", obs(), S_LD); else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if ({detect_add, ld_state, write_enb_reg, busy} !== 4'b1000) $display("FAIL arst_now got=%b exp=1000", {detect_add, ld_state, write_enb_reg, busy}); else passed++;
        total++; if ({fifo_sel, addr_out} !== 5'b0) $display("FAIL arst_sel got=%b exp=0", {fifo_sel, addr_out}); else passed++;
        pkt_valid = 1'b0;
        #2 reset = 1'b0;
        tick();
        total++; if (obs() !== S_DA) $display("FAIL arst_after got=%0d exp=%0d", obs(), S_DA); else passed++;
    endtask

    initial begin
        reset = 1'b1; pkt_valid = 1'b0; data_in = '0; parity_done = 1'b0;
        low_pkt_valid = 1'b0; fifo_full = 1'b0; fifo_empty = 3'b111; soft_reset = 3'b000;
        test_reset();
        test_basic_packet();
        test_wait_release();
        test_timeout();
        test_invalid_addr();
        test_fifo_full();
        test_soft_reset();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
